// File: rtl/wr_console_pkg.sv
// Shared constants for the WR console word FIFO, the UART monitor and the IPbus readout.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: bridge word addresses, STATUS field positions, CONTROL bit indices,
// bus FSM state type and a STATUS word packing helper.
package wr_console_pkg;

  localparam logic [5:0] FIFO_ADDR    = 6'h10;
  localparam logic [5:0] STATUS_ADDR  = 6'h14;
  localparam logic [5:0] CONTROL_ADDR = 6'h18;

  localparam int unsigned STATUS_EMPTY_BIT = 16;
  localparam int unsigned STATUS_FULL_BIT  = 17;
  localparam int unsigned STATUS_OVF_LSB   = 24;

  localparam int unsigned CTRL_FLUSH   = 0;
  localparam int unsigned CTRL_CLR_OVF = 1;

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_ACK  = 1'b1
  } bus_state_e;

  // STATUS layout: [31:24] overflow count, [17] full, [16] empty, [15:0] level.
  function automatic logic [31:0] status_word(input logic [15:0] level,
                                              input logic        empty,
                                              input logic        full,
                                              input logic [7:0]  ovf_count);
    return {ovf_count, 6'b0, full, empty, level};
  endfunction

endpackage

// File: rtl/wr_console_fifo_if.sv
// Bridge bus bundle between the WR UART monitor (master) and the console FIFO (slave).
// Latency: n/a (wires only).
// Backpressure: master holds read/write until a one-cycle acknowledge, drops it the cycle after.
// Signals: bus_read, bus_write, bus_byte_enable[3:0], bus_address[5:0], bus_write_data[31:0]
// (master->slave); bus_acknowledge, bus_read_data[31:0] (slave->master).
interface wr_console_fifo_if;
  logic        bus_read;
  logic        bus_write;
  logic [3:0]  bus_byte_enable;
  logic [5:0]  bus_address;
  logic [31:0] bus_write_data;
  logic        bus_acknowledge;
  logic [31:0] bus_read_data;

  modport master (
    output bus_read, bus_write, bus_byte_enable, bus_address, bus_write_data,
    input  bus_acknowledge, bus_read_data
  );

  modport slave (
    input  bus_read, bus_write, bus_byte_enable, bus_address, bus_write_data,
    output bus_acknowledge, bus_read_data
  );
endinterface

// File: rtl/wr_console_ram.sv
// Simple dual-port word store for the console FIFO, written from the bus, read by pointer.
// Latency: 1 cycle registered read; a read of the address being written returns the old word.
// Backpressure: none; every write and read is taken each cycle.
// Ports: clock; wr_en_i/wr_addr_i/wr_data_i write port; rd_addr_i read address; rd_data_o read word.
module wr_console_ram #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clock,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rd_data_q;

  // No reset on the array or read register so the tools can map this onto block RAM.
  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      mem[wr_addr_i] <= wr_data_i;
    end
    rd_data_q <= mem[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/wr_console_fifo.sv
// Bridge-slave console word FIFO: bus pushes/peeks/status/control, FWFT stream drain toward IPbus.
// Latency: ack 1 cycle after accept; a word pushed into an empty FIFO is valid 2 cycles after accept.
// Backpressure: stream pops on valid&ready; pushes into a full FIFO are dropped, acked and counted.
// Ports: clock, nreset; bus (bridge slave modport); stream_data/stream_valid/stream_ready;
// fifo_level occupancy; overflow_pulse one cycle per dropped push.
module wr_console_fifo
  import wr_console_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2      = 9,
  parameter logic [5:0]  FIFO_ADDRESS    = FIFO_ADDR,
  parameter logic [5:0]  STATUS_ADDRESS  = STATUS_ADDR,
  parameter logic [5:0]  CONTROL_ADDRESS = CONTROL_ADDR
) (
  input  logic                  clock,
  input  logic                  nreset,
  wr_console_fifo_if.slave      bus,
  output logic [31:0]           stream_data,
  output logic                  stream_valid,
  input  logic                  stream_ready,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic                  overflow_pulse
);

  localparam int unsigned PTR_W = DEPTH_LOG2;
  localparam int unsigned LVL_W = DEPTH_LOG2 + 1;
  localparam logic [LVL_W-1:0] FULL_LEVEL = {1'b1, {PTR_W{1'b0}}};

  bus_state_e        state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [LVL_W-1:0]  level_after_pop;
  logic              valid_q, valid_d;
  logic [7:0]        ovf_q, ovf_d;
  logic              ovf_pulse_q;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       ram_rd_data;

  logic accept, is_write, is_read;
  logic push_req, push_ok, drop, pop, ctrl_wr, flush, clr_ovf, full, empty;

  // Bus FSM: a request is only taken in IDLE, so the request still held during ACK is not re-accepted.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      BUS_IDLE: begin
        if (bus.bus_read || bus.bus_write) begin
          accept  = 1'b1;
          state_d = BUS_ACK;
        end
      end
      BUS_ACK:  state_d = BUS_IDLE;
      default:  state_d = BUS_IDLE;
    endcase
  end

  // Write wins when read and write are both raised.
  assign is_write = accept && bus.bus_write;
  assign is_read  = accept && bus.bus_read && !bus.bus_write;

  assign full     = (level_q == FULL_LEVEL);
  assign empty    = (level_q == '0);
  assign pop      = valid_q && stream_ready;
  assign push_req = is_write && (bus.bus_address == FIFO_ADDRESS) && (bus.bus_byte_enable == 4'hF);
  assign push_ok  = push_req && (!full || pop);
  assign drop     = push_req && !push_ok;
  assign ctrl_wr  = is_write && (bus.bus_address == CONTROL_ADDRESS) && bus.bus_byte_enable[0];
  assign flush    = ctrl_wr && bus.bus_write_data[CTRL_FLUSH];
  assign clr_ovf  = ctrl_wr && bus.bus_write_data[CTRL_CLR_OVF];

  assign level_after_pop = level_q - LVL_W'(pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    level_d  = level_after_pop + LVL_W'(push_ok);
    // The RAM is read at the next head address; that read only returns the head word if it was
    // written before this edge. A word pushed now into an otherwise empty FIFO therefore shows
    // one cycle later, once the read has seen the write.
    valid_d  = (level_after_pop != '0);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      valid_d  = 1'b0;
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (clr_ovf) begin
      ovf_d = '0;
    end else if (drop && (ovf_q != 8'hFF)) begin
      ovf_d = ovf_q + 8'd1;
    end
  end

  always_comb begin
    rdata_d = '0;
    if (is_read) begin
      if (bus.bus_address == FIFO_ADDRESS) begin
        rdata_d = stream_data;
      end else if (bus.bus_address == STATUS_ADDRESS) begin
        rdata_d = status_word(16'(level_q), empty, full, ovf_q);
      end
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q     <= BUS_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      valid_q     <= 1'b0;
      ovf_q       <= '0;
      ovf_pulse_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      valid_q     <= valid_d;
      ovf_q       <= ovf_d;
      ovf_pulse_q <= drop;
      rdata_q     <= rdata_d;
    end
  end

  wr_console_ram #(
    .ADDR_W (PTR_W),
    .DATA_W (32)
  ) u_ram (
    .clock     (clock),
    .wr_en_i   (push_ok),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (bus.bus_write_data),
    .rd_addr_i (rd_ptr_d),
    .rd_data_o (ram_rd_data)
  );

  // The RAM output is uninitialised after reset and stale while not valid; hide it.
  assign stream_data         = valid_q ? ram_rd_data : '0;
  assign stream_valid        = valid_q;
  assign fifo_level          = level_q;
  assign overflow_pulse      = ovf_pulse_q;
  assign bus.bus_acknowledge = (state_q == BUS_ACK);
  assign bus.bus_read_data   = rdata_q;

endmodule

// File: tb/tb_wr_console_fifo.sv
module tb_wr_console_fifo;

  logic        clock = 1'b0;
  logic        nreset;
  logic [31:0] stream_data;
  logic        stream_valid;
  logic        stream_ready;
  logic [2:0]  fifo_level;
  logic        overflow_pulse;

  int checks   = 0;
  int failures = 0;

  wr_console_fifo_if bif ();

  wr_console_fifo #(.DEPTH_LOG2(2)) dut (
    .clock          (clock),
    .nreset         (nreset),
    .bus            (bif),
    .stream_data    (stream_data),
    .stream_valid   (stream_valid),
    .stream_ready   (stream_ready),
    .fifo_level     (fifo_level),
    .overflow_pulse (overflow_pulse)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [5:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rdy;
    logic [31:0] exp_rdata;
    logic [2:0]  exp_level;
    logic        exp_ovf;
  } vec_t;

  localparam int NV = 19;
  vec_t tbl [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One bridge transaction: request held until ack, dropped at the edge ending the ack cycle.
  task automatic bus_op(input logic rd, input logic wr, input logic [5:0] addr,
                        input logic [3:0] be, input logic [31:0] wdata, input logic rdy,
                        output logic [31:0] rdata, output logic ovf, output logic [2:0] lvl,
                        output logic vld, output int nack,
                        output logic vld2, output logic [31:0] dat2);
    logic got;
    got   = 1'b0;
    rdata = '0; ovf = 1'b0; lvl = '0; vld = 1'b0; nack = 0;
    @(negedge clock);
    bif.bus_read        = rd;
    bif.bus_write       = wr;
    bif.bus_address     = addr;
    bif.bus_byte_enable = be;
    bif.bus_write_data  = wdata;
    stream_ready        = rdy;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      stream_ready = 1'b0;
      if (bif.bus_acknowledge) begin
        got = 1'b1;
        break;
      end
    end
    if (got) begin
      nack  = 1;
      rdata = bif.bus_read_data;
      ovf   = overflow_pulse;
      lvl   = fifo_level;
      vld   = stream_valid;
    end else begin
      checks++;
      failures++;
      $display("FAIL ack_timeout addr=%h actual=no_ack required=ack", addr);
    end
    @(posedge clock);
    #1;
    bif.bus_read  = 1'b0;
    bif.bus_write = 1'b0;
    @(negedge clock);
    if (bif.bus_acknowledge) nack++;
    vld2 = stream_valid;
    dat2 = stream_data;
  endtask

  // Drain four words with ready held high, comparing arrival order.
  task automatic drain4(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                        input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] exp [4];
    int k;
    exp = '{e0, e1, e2, e3};
    k = 0;
    @(negedge clock);
    stream_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (stream_valid) begin
        chk($sformatf("%s_word%0d", tag, k), stream_data, exp[k]);
        k++;
      end
      if (k == 4) begin
        @(posedge clock);
        #1;
        break;
      end
      @(negedge clock);
    end
    stream_ready = 1'b0;
    if (k != 4) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=%0d required=4", tag, k);
    end
    @(negedge clock);
    chk({tag, "_valid_after"}, 32'(stream_valid), 32'd0);
  endtask

  logic [31:0] rd_d, dat2;
  logic        ovf_p, vld, vld2;
  logic [2:0]  lvl;
  int          nack;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nreset              = 1'b0;
    bif.bus_read        = 1'b0;
    bif.bus_write       = 1'b0;
    bif.bus_address     = '0;
    bif.bus_byte_enable = '0;
    bif.bus_write_data  = '0;
    stream_ready        = 1'b0;

    //          rd  wr  addr   be    wdata          rdy  exp_rdata      lvl ovf
    tbl[0]  = '{1'b1, 1'b0, 6'h10, 4'hF, 32'h0,        1'b0, 32'h41424344, 3'd1, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 6'h10, 4'hF, 32'h2,        1'b0, 32'h0,        3'd2, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 6'h10, 4'h3, 32'hDEAD,     1'b0, 32'h0,        3'd2, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 6'h10, 4'hF, 32'h3,        1'b0, 32'h0,        3'd3, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 6'h10, 4'hF, 32'h4,        1'b0, 32'h0,        3'd4, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 6'h14, 4'hF, 32'h0,        1'b0, 32'h00020004, 3'd4, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 6'h10, 4'hF, 32'h5,        1'b0, 32'h0,        3'd4, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 6'h14, 4'hF, 32'h0,        1'b0, 32'h01020004, 3'd4, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 6'h3C, 4'hF, 32'h0,        1'b0, 32'h0,        3'd4, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 6'h3C, 4'hF, 32'h12345678, 1'b0, 32'h0,        3'd4, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 6'h18, 4'hF, 32'h0,        1'b0, 32'h0,        3'd4, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 6'h18, 4'hE, 32'h3,        1'b0, 32'h0,        3'd4, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 6'h10, 4'hF, 32'h0,        1'b0, 32'h41424344, 3'd4, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 6'h14, 4'hF, 32'h0,        1'b0, 32'h01020004, 3'd4, 1'b0};
    tbl[14] = '{1'b1, 1'b1, 6'h10, 4'hF, 32'h6,        1'b0, 32'h0,        3'd4, 1'b1};
    tbl[15] = '{1'b1, 1'b0, 6'h14, 4'hF, 32'h0,        1'b0, 32'h02020004, 3'd4, 1'b0};
    tbl[16] = '{1'b0, 1'b1, 6'h10, 4'hF, 32'h7,        1'b1, 32'h0,        3'd4, 1'b0};
    tbl[17] = '{1'b1, 1'b0, 6'h10, 4'hF, 32'h0,        1'b0, 32'h2,        3'd4, 1'b0};
    tbl[18] = '{1'b1, 1'b0, 6'h14, 4'hF, 32'h0,        1'b0, 32'h02020004, 3'd4, 1'b0};

    repeat (2) @(negedge clock);
    chk("rst_ack",      32'(bif.bus_acknowledge), 32'd0);
    chk("rst_rdata",    bif.bus_read_data,        32'd0);
    chk("rst_valid",    32'(stream_valid),        32'd0);
    chk("rst_data",     stream_data,              32'd0);
    chk("rst_level",    32'(fifo_level),          32'd0);
    chk("rst_ovf",      32'(overflow_pulse),      32'd0);
    nreset = 1'b1;

    // Reset asserted during the ack cycle of a push.
    @(negedge clock);
    bif.bus_write = 1'b1; bif.bus_address = 6'h10;
    bif.bus_byte_enable = 4'hF; bif.bus_write_data = 32'hCAFEBABE;
    @(negedge clock);
    chk("midack_ack_before", 32'(bif.bus_acknowledge), 32'd1);
    nreset = 1'b0;
    #1;
    chk("midack_ack",   32'(bif.bus_acknowledge), 32'd0);
    chk("midack_level", 32'(fifo_level),          32'd0);
    chk("midack_valid", 32'(stream_valid),        32'd0);
    bif.bus_write = 1'b0;
    @(negedge clock);
    nreset = 1'b1;
    repeat (3) @(negedge clock);
    chk("midack_after_level", 32'(fifo_level),          32'd0);
    chk("midack_after_valid", 32'(stream_valid),        32'd0);
    chk("midack_after_ack",   32'(bif.bus_acknowledge), 32'd0);

    // First push into an empty FIFO.
    bus_op(1'b0, 1'b1, 6'h10, 4'hF, 32'h41424344, 1'b0, rd_d, ovf_p, lvl, vld, nack, vld2, dat2);
    chk("push1_acks",      32'(nack), 32'd1);
    chk("push1_level",     32'(lvl),  32'd1);
    chk("push1_valid_ack", 32'(vld),  32'd0);
    chk("push1_valid_2",   32'(vld2), 32'd1);
    chk("push1_data_2",    dat2,      32'h41424344);

    for (int i = 0; i < NV; i++) begin
      bus_op(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].be, tbl[i].wdata, tbl[i].rdy,
             rd_d, ovf_p, lvl, vld, nack, vld2, dat2);
      chk($sformatf("vec%0d_rdata", i), rd_d,         tbl[i].exp_rdata);
      chk($sformatf("vec%0d_level", i), 32'(lvl),     32'(tbl[i].exp_level));
      chk($sformatf("vec%0d_ovf",   i), 32'(ovf_p),   32'(tbl[i].exp_ovf));
      chk($sformatf("vec%0d_acks",  i), 32'(nack),    32'd1);
    end

    drain4("drain1", 32'h2, 32'h3, 32'h4, 32'h7);
    bus_op(1'b1, 1'b0, 6'h14, 4'hF, 32'h0, 1'b0, rd_d, ovf_p, lvl, vld, nack, vld2, dat2);
    chk("drain1_status", rd_d, 32'h02010000);

    // Pointers now sit mid-array; four more pushes wrap them.
    for (int i = 0; i < 4; i++) begin
      bus_op(1'b0, 1'b1, 6'h10, 4'hF, 32'hA0 + 32'(i), 1'b0, rd_d, ovf_p, lvl, vld, nack, vld2, dat2);
      chk($sformatf("wrap_push%0d_level", i), 32'(lvl), 32'(i + 1));
    end
    drain4("drain2", 32'hA0, 32'hA1, 32'hA2, 32'hA3);
    bus_op(1'b1, 1'b0, 6'h14, 4'hF, 32'h0, 1'b0, rd_d, ovf_p, lvl, vld, nack, vld2, dat2);
    chk("drain2_status", rd_d, 32'h02010000);

    // Build level=3, overflow count=7, then flush and clear together.
    for (int i = 0; i < 9; i++) begin
      bus_op(1'b0, 1'b1, 6'h10, 4'hF, 32'hB0 + 32'(i), 1'b0, rd_d, ovf_p, lvl, vld, nack, vld2, dat2);
    end
    @(negedge clock);
    stream_ready = 1'b1;
    @(negedge clock);
    stream_ready = 1'b0;
    bus_op(1'b1, 1'b0, 6'h14, 4'hF, 32'h0, 1'b0, rd_d, ovf_p, lvl, vld, nack, vld2, dat2);
    chk("preflush_status", rd_d, 32'h07000003);
    bus_op(1'b0, 1'b1, 6'h18, 4'hF, 32'h3, 1'b0, rd_d, ovf_p, lvl, vld, nack, vld2, dat2);
    chk("flush_level", 32'(lvl), 32'd0);
    chk("flush_valid", 32'(vld), 32'd0);
    chk("flush_valid_after", 32'(vld2), 32'd0);
    bus_op(1'b1, 1'b0, 6'h14, 4'hF, 32'h0, 1'b0, rd_d, ovf_p, lvl, vld, nack, vld2, dat2);
    chk("flush_status", rd_d, 32'h00010000);

    // Saturation of the overflow count.
    for (int i = 0; i < 4; i++) begin
      bus_op(1'b0, 1'b1, 6'h10, 4'hF, 32'hC0 + 32'(i), 1'b0, rd_d, ovf_p, lvl, vld, nack, vld2, dat2);
    end
    for (int i = 0; i < 300; i++) begin
      bus_op(1'b0, 1'b1, 6'h10, 4'hF, 32'hEE, 1'b0, rd_d, ovf_p, lvl, vld, nack, vld2, dat2);
    end
    chk("sat_last_ovf_pulse", 32'(ovf_p), 32'd1);
    bus_op(1'b1, 1'b0, 6'h14, 4'hF, 32'h0, 1'b0, rd_d, ovf_p, lvl, vld, nack, vld2, dat2);
    chk("sat_status", rd_d, 32'hFF020004);
    bus_op(1'b0, 1'b1, 6'h18, 4'hF, 32'h2, 1'b0, rd_d, ovf_p, lvl, vld, nack, vld2, dat2);
    bus_op(1'b1, 1'b0, 6'h14, 4'hF, 32'h0, 1'b0, rd_d, ovf_p, lvl, vld, nack, vld2, dat2);
    chk("clrovf_status", rd_d, 32'h00020004);
    bus_op(1'b1, 1'b0, 6'h10, 4'hF, 32'h0, 1'b0, rd_d, ovf_p, lvl, vld, nack, vld2, dat2);
    chk("clrovf_head", rd_d, 32'hC0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
